// File: rtl/stream_demux_two_out.sv
// Registered 1-to-2 stream demultiplexer with one holding register per output.
// Destination comes from demux_select or an internal ping-pong pointer.
module stream_demux_two_out #(
    parameter int DATA_W = 1728,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              demux_select,
    input  logic              pingpong_en,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out2_data,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic              pp_ptr,
    output logic [CNT_W-1:0]  out1_count,
    output logic [CNT_W-1:0]  out2_count
);

    logic tgt;
    logic free1;
    logic free2;
    logic accept;
    logic load1;
    logic load2;
    logic drain1;
    logic drain2;

    assign tgt    = pingpong_en ? pp_ptr : demux_select;
    assign drain1 = out1_valid & out1_ready;
    assign drain2 = out2_valid & out2_ready;
    // A register draining this cycle can take a new word on the same edge.
    assign free1  = ~out1_valid | out1_ready;
    assign free2  = ~out2_valid | out2_ready;

    assign in_ready = tgt ? free2 : free1;
    assign accept   = in_valid & in_ready;
    assign load1    = accept & ~tgt;
    assign load2    = accept & tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_data  <= '0;
            out1_valid <= 1'b0;
            out1_count <= '0;
        end else begin
            if (load1) begin
                out1_data  <= in_data;
                out1_valid <= 1'b1;
            end else if (drain1) begin
                out1_valid <= 1'b0;
            end
            if (drain1) begin
                out1_count <= out1_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out2_data  <= '0;
            out2_valid <= 1'b0;
            out2_count <= '0;
        end else begin
            if (load2) begin
                out2_data  <= in_data;
                out2_valid <= 1'b1;
            end else if (drain2) begin
                out2_valid <= 1'b0;
            end
            if (drain2) begin
                out2_count <= out2_count + CNT_W'(1);
            end
        end
    end

    // Pointer advances only on ping-pong accepts, so select mode leaves it parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_ptr <= 1'b0;
        end else if (accept && pingpong_en) begin
            pp_ptr <= ~pp_ptr;
        end
    end

endmodule

// File: tb/tb_stream_demux_two_out.sv
// Randomized bench for stream_demux_two_out against a queue-based reference model.
module tb_stream_demux_two_out;

    localparam int DATA_W = 1728;
    localparam int CNT_W  = 16;

    typedef logic [DATA_W-1:0] word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    word_t       in_data = '0;
    logic        in_valid = 1'b0;
    logic        demux_select = 1'b0;
    logic        pingpong_en = 1'b0;
    logic        out1_ready = 1'b0;
    logic        out2_ready = 1'b0;

    logic        in_ready;
    word_t       out1_data, out2_data;
    logic        out1_valid, out2_valid, pp_ptr;
    logic [CNT_W-1:0] out1_count, out2_count;

    logic        w4_in_ready;
    word_t       w4_out1_data, w4_out2_data;
    logic        w4_out1_valid, w4_out2_valid, w4_pp_ptr;
    logic [3:0]  w4_out1_count, w4_out2_count;

    stream_demux_two_out #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .demux_select(demux_select), .pingpong_en(pingpong_en),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
        .pp_ptr(pp_ptr), .out1_count(out1_count), .out2_count(out2_count)
    );

    stream_demux_two_out #(.DATA_W(DATA_W), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(w4_in_ready), .demux_select(demux_select), .pingpong_en(pingpong_en),
        .out1_data(w4_out1_data), .out1_valid(w4_out1_valid), .out1_ready(out1_ready),
        .out2_data(w4_out2_data), .out2_valid(w4_out2_valid), .out2_ready(out2_ready),
        .pp_ptr(w4_pp_ptr), .out1_count(w4_out1_count), .out2_count(w4_out2_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each output holds at most one word in its queue.
    word_t       q1[$];
    word_t       q2[$];
    word_t       last1 = '0;
    word_t       last2 = '0;
    bit          m_ptr = 1'b0;
    logic [15:0] m_cnt1 = '0;
    logic [15:0] m_cnt2 = '0;

    function automatic logic [63:0] fold(input word_t w);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < DATA_W / 64; i++) f ^= w[i*64 +: 64];
        return f;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q2.delete();
        last1  = '0;
        last2  = '0;
        m_ptr  = 1'b0;
        m_cnt1 = '0;
        m_cnt2 = '0;
    endtask

    task automatic check_regs();
        check("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
        check("out2_valid", 64'(out2_valid), 64'(q2.size() != 0));
        check("out1_data", fold(out1_data), fold(last1));
        check("out2_data", fold(out2_data), fold(last2));
        check("pp_ptr", 64'(pp_ptr), 64'(m_ptr));
        check("out1_count", 64'(out1_count), 64'(m_cnt1));
        check("out2_count", 64'(out2_count), 64'(m_cnt2));
        check("w4_out1_count", 64'(w4_out1_count), 64'(m_cnt1[3:0]));
        check("w4_out2_count", 64'(w4_out2_count), 64'(m_cnt2[3:0]));
    endtask

    // One clock: check held state, apply inputs, check in_ready, advance the model.
    task automatic cycle(input bit iv, input word_t d, input bit sel, input bit pp,
                         input bit r1, input bit r2);
        bit tgt;
        bit exp_rdy;
        @(negedge clk);
        check_regs();
        in_valid     = iv;
        in_data      = iv ? d : rand_word();
        demux_select = sel;
        pingpong_en  = pp;
        out1_ready   = r1;
        out2_ready   = r2;
        #1;
        tgt     = pp ? m_ptr : sel;
        exp_rdy = tgt ? (q2.size() == 0 || r2) : (q1.size() == 0 || r1);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (q1.size() != 0 && r1) begin
            void'(q1.pop_front());
            m_cnt1++;
        end
        if (q2.size() != 0 && r2) begin
            void'(q2.pop_front());
            m_cnt2++;
        end
        if (iv && exp_rdy) begin
            if (tgt) begin
                q2.push_back(d);
                last2 = d;
            end else begin
                q1.push_back(d);
                last1 = d;
            end
            if (pp) m_ptr = ~m_ptr;
        end
    endtask

    initial begin
        word_t pat_a;
        word_t pat_b;
        word_t w;
        pat_a = {(DATA_W/8){8'hA5}};
        pat_b = {(DATA_W/8){8'h5A}};

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Select routing.
        cycle(1, pat_a, 0, 0, 1, 1);
        cycle(1, pat_b, 1, 0, 1, 1);
        cycle(0, '0, 0, 0, 1, 1);
        cycle(0, '0, 0, 0, 1, 1);

        // Backpressure isolation.
        cycle(1, rand_word(), 0, 0, 0, 1);
        cycle(1, rand_word(), 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, rand_word(), 1, 0, 0, 1);
        cycle(0, '0, 0, 0, 1, 1);

        // Ping-pong, eight back-to-back words.
        for (int i = 0; i < 8; i++) begin
            w = '0;
            w[31:0] = 32'(i);
            cycle(1, w, 0, 1, 1, 1);
        end
        cycle(0, '0, 0, 0, 1, 1);

        // Full-rate drain and load on out1, then a run that wraps the 4-bit counter.
        for (int i = 0; i < 10; i++) cycle(1, rand_word(), 0, 0, 1, 0);
        for (int i = 0; i < 17; i++) cycle(1, rand_word(), 0, 0, 1, 0);
        cycle(0, '0, 0, 0, 1, 1);

        // Alternating outputs with each consumer ready every other cycle.
        for (int i = 0; i < 12; i++) cycle(1, rand_word(), 1'(i), 0, 1'(i), ~1'(i));
        cycle(0, '0, 0, 0, 1, 1);

        // Reset mid-stream with both registers full.
        cycle(1, rand_word(), 0, 0, 0, 0);
        cycle(1, rand_word(), 1, 0, 0, 0);
        @(negedge clk);
        check_regs();
        #2;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        #1;
        model_reset();
        check("midrst_out1_valid", 64'(out1_valid), 64'd0);
        check("midrst_out2_valid", 64'(out2_valid), 64'd0);
        check("midrst_counts", {32'(out1_count), 32'(out2_count)}, 64'd0);
        @(negedge clk);
        check_regs();
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Randomized traffic, mixing modes mid-stream.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_word(), 1'($urandom()),
                  1'($urandom_range(0, 2) == 0), 1'($urandom()), 1'($urandom()));
        end
        cycle(0, '0, 0, 0, 1, 1);
        cycle(0, '0, 0, 0, 1, 1);
        @(negedge clk);
        check_regs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux_two_out.md
# stream_demux_two_out

Registered 1-to-2 stream demultiplexer for 1728-bit data words, the splitting counterpart of the two-input word mux in the datapath. It accepts one word per cycle on a valid/ready input channel and steers each word to one of two output channels. Steering uses either an explicit select or an internal ping-pong pointer. Each output has a single-entry holding register, so a stalled consumer back-pressures only words destined for it. Per-output handshake counters support bring-up and verification.

## Interface
Parameters:
- DATA_W, 1728, word width in bits.
- CNT_W, 16, width of the per-output word counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  input word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts the word this cycle.
- demux_select  input  1  destination in select mode: 0 routes to out1, 1 routes to out2.
- pingpong_en  input  1  1 selects ping-pong mode, 0 selects select mode.
- out1_data  output  DATA_W  held word for channel 1.
- out1_valid  output  1  out1_data is valid.
- out1_ready  input  1  consumer 1 takes the word.
- out2_data  output  DATA_W  held word for channel 2.
- out2_valid  output  1  out2_data is valid.
- out2_ready  input  1  consumer 2 takes the word.
- pp_ptr  output  1  next ping-pong destination: 0 is out1, 1 is out2.
- out1_count  output  CNT_W  number of completed out1 handshakes, modulo 2^CNT_W.
- out2_count  output  CNT_W  number of completed out2 handshakes, modulo 2^CNT_W.

## Operation
- Destination: tgt = pp_ptr when pingpong_en is 1, otherwise demux_select. Both inputs are sampled every cycle; no latching.
- Holding register X (X = 1 or 2) is free when outX_valid = 0, or when outX_valid & outX_ready (draining this cycle).
- in_ready = (register tgt is free). This is combinational from out*_ready, pingpong_en, demux_select and pp_ptr.
- Accept: in_valid & in_ready. Register tgt loads in_data and sets outX_valid = 1.
- Drain: outX_valid & outX_ready with no load into X. This clears outX_valid; outX_data holds its last value.
- Simultaneous drain and load on the same register: the new word is loaded, outX_valid stays 1, and the count still increments.
- The non-target register is never written by an accept. It drains independently.
- pp_ptr toggles on every accept made while pingpong_en = 1. It holds while pingpong_en = 0, so switching modes mid-stream resumes from the stored pointer.
- Counters: outX_count increments by 1 on every outX handshake and wraps from 2^CNT_W-1 to 0.
- Words are never dropped or duplicated. Per-output order equals input order for words routed to that output.
- in_data is ignored when in_valid = 0. Changing demux_select while in_valid = 1 and in_ready = 0 is legal; the word goes to whatever tgt is on the accept cycle.

## Timing
- Reset (rst_n low, asynchronous) forces: out1_valid = out2_valid = 0, out1_data = out2_data = 0, pp_ptr = 0, out1_count = out2_count = 0. in_ready then follows its combinational rule (1 after reset, since both registers are empty).
- Reset asserted mid-operation discards held words immediately. No handshake completes in a cycle during which rst_n is low.
- Latency: a word accepted at edge N appears with outX_valid = 1 in the cycle after edge N. That is one cycle of latency.
- Throughput: one word per cycle to a single output if its consumer holds ready = 1. Alternating outputs sustain one word per cycle even if each consumer accepts only every other cycle.
- Backpressure: a full register whose consumer is not ready deasserts in_ready only while tgt points at it.
- Counter and pp_ptr updates become visible the cycle after the causing handshake.

## Test plan
- Reset/idle: hold rst_n = 0, then release with in_valid = 0 -> all outputs 0, in_ready = 1, pp_ptr = 0, counts 0.
- Select routing: pingpong_en = 0, send A5A5…, then 5A5A…, with demux_select = 0 then 1 and both readies = 1 -> out1 gets A5A5…, out2 gets 5A5A…, each one cycle after accept; out1_count = out2_count = 1.
- Backpressure isolation: out1_ready = 0, out1 holding a word, select = 0 -> in_ready = 0. Switch select to 1 -> in_ready = 1; words reach out2 while out1_data is unchanged.
- Ping-pong: pingpong_en = 1, send words 0..7 back-to-back with both readies = 1 -> even words on out1, odd words on out2; pp_ptr = 0 at the end; each count = 4.
- Full-rate drain and load: out1_ready = 1, select = 0, 10 consecutive words -> in_ready stays 1, outputs arrive in order with no gaps, out1_count = 10. With CNT_W = 4 and 17 words, out1_count = 1.
- Reset mid-stream: assert rst_n = 0 while both registers are valid -> both valids clear immediately, counts return to 0, and no spurious handshake occurs after release.
